stream_to_memory: RTL
=====================

# stream_to_memory

Avalon-ST to Avalon-MM write DMA: accepts one packet of 16-bit words on a streaming sink and writes them to consecutive halfword addresses through a write master. It is the write-side counterpart of the memory-to-stream reader in the inference-engine pd_block. Software configures and starts it over a 4-bit CSR slave and polls its status. A small FIFO decouples sink backpressure from master waitrequest.

## Interface
- FIFO_DEPTH, 4, sink-to-master buffer depth in words; power of two, ≥2
- clock  in  1  single clock, all logic rising-edge
- clock_sreset  in  1  synchronous active-high reset
- s_address  in  4  CSR word address
- s_readdata  out  32  CSR read data
- s_writedata  in  32  CSR write data
- s_read / s_write  in  1  CSR strobes
- s_waitrequest  out  1  CSR stall
- rm_address  out  32  byte address of current write
- rm_writedata  out  16  write data
- rm_byteenable  out  2  always 2'b11 out of reset
- rm_write  out  1  write request
- rm_waitrequest  in  1  slave stall
- st_ready  out  1  sink ready (readyLatency 0)
- st_valid / st_sop / st_eop  in  1  sink qualifiers
- st_data  in  16  sink data

## Operation
- CSR map: 0x0 control/status: write bit0=1 = go; read {28'b0, no_eop, short, busy, 1'b0}. 0x1 pointer (32b RW). 0x2 word_count (24b RW, reads zero-extended). 0x3 words_written (24b RO). Other addresses read 0, writes ignored.
- go ignored while busy or when word_count==0 (busy stays 0).
- On accepted go: latch pointer→rm_address, word_count→target, clear accepted/words_written/short/no_eop, busy=1, state HUNT.
- HUNT: st_ready=1; beats without st_sop discarded; beat with st_sop is first data beat, state RUN.
- RUN: st_ready = ~fifo_full & (accepted < target). Each accepted beat pushed to FIFO, accepted+1.
  - st_eop on beat with accepted+1 < target: set short, stop accepting, state DRAIN.
  - Beat with accepted+1 == target: state DRAIN; if st_eop=0 set no_eop. Remainder of packet is not consumed.
  - sop+eop single-beat packet is legal.
- Write master (RUN and DRAIN): rm_write = fifo non-empty, rm_writedata = FIFO head. On rm_write & ~rm_waitrequest: pop, rm_address += 2 (32-bit wrap), words_written+1.
- DRAIN: when FIFO empty, busy=0, state IDLE. IDLE: st_ready=0, rm_write=0.
- CSR writes to pointer/word_count while busy update registers only; active transfer uses latched copies.
- Reset (any state, mid-transfer included): state IDLE; busy, short, no_eop, rm_write, st_ready, s_readdata, pointer, word_count, words_written, rm_address = 0; FIFO emptied; rm_byteenable = 2'b11.

## Timing
- CSR write: zero wait states. CSR read: s_waitrequest = s_read & ~read_latency; data registered, valid in second cycle; read_latency toggles back to 0 after the completing cycle.
- go written cycle N: busy reads 1 from N+2; st_ready may assert N+2.
- Beat accepted cycle N: earliest rm_write cycle N+1 (FIFO registered).
- While rm_waitrequest=1: rm_address, rm_writedata, rm_write held stable.
- Simultaneous push and pop on full or empty FIFO: both honoured; count unchanged; no loss or duplication.
- Sustained throughput 1 word/cycle with rm_waitrequest=0 and st_valid=1.
- busy falls the cycle after the final write handshake.

## Test plan
- pointer=0x1000, count=4, packet 0xA001..0xA004 sop/eop, no stalls -> writes to 0x1000/02/04/06 with matching data; status 0x0 after done; words_written=4.
- count=8, rm_waitrequest high 3 of every 4 cycles -> st_ready drops with 4 words buffered; address/data stable under stall; 8 correct writes in order.
- count=8, eop on 3rd beat -> 3 writes, status=0x4, words_written=3, st_ready 0 after eop.
- count=2, 5-beat packet with eop on beat 5 -> 2 writes, status=0x8, beats 3-5 left unaccepted.
- 2 beats without sop then 3-beat sop/eop packet, count=3 -> junk discarded, writes contain only packet data.
- go with count=0 -> busy never 1; clock_sreset mid-transfer -> next cycle rm_write=0, st_ready=0, status=0, words_written=0.

Source files
------------

// File: rtl/stream_to_memory.sv
// Streaming-sink to memory-mapped write DMA: one packet of 16-bit words is buffered
// through a small FIFO and written to consecutive halfword addresses.
//
// state | meaning
// IDLE  | waiting for go; sink and master quiet
// HUNT  | sink ready, discarding beats until start-of-packet
// RUN   | accepting packet beats into the FIFO while the master drains it
// DRAIN | sink closed; master empties the FIFO, then back to IDLE
module stream_to_memory #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        clock_sreset,
  input  logic [3:0]  s_address,
  output logic [31:0] s_readdata,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  input  logic        s_write,
  output logic        s_waitrequest,
  output logic [31:0] rm_address,
  output logic [15:0] rm_writedata,
  output logic [1:0]  rm_byteenable,
  output logic        rm_write,
  input  logic        rm_waitrequest,
  output logic        st_ready,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  input  logic [15:0] st_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HUNT, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pointer;
  logic [23:0] word_count;
  logic [23:0] target;
  logic [23:0] accepted;
  logic [23:0] accepted_inc;
  logic [23:0] words_written;
  logic        short_pkt;
  logic        no_eop;
  logic        busy;
  logic        read_latency;
  logic [31:0] rd_mux;
  logic        go;
  logic        push;
  logic        pop;
  logic        last_beat;
  logic        short_beat;

  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count, fifo_count_nxt;
  logic          fifo_full, fifo_empty;

  assign rm_byteenable = 2'b11;
  assign busy          = (state != IDLE);
  assign fifo_full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign rm_writedata  = fifo_mem[rd_ptr];

  assign go = s_write && (s_address == 4'h0) && s_writedata[0] &&
              (state == IDLE) && (word_count != 24'd0);

  assign push = st_valid && st_ready &&
                ((state == RUN) || ((state == HUNT) && st_sop));
  assign pop  = rm_write && !rm_waitrequest;

  assign accepted_inc = accepted + 24'd1;
  assign last_beat    = push && (accepted_inc == target);
  assign short_beat   = push && st_eop && (accepted_inc < target);

  always_comb begin
    fifo_count_nxt = fifo_count;
    if (push && !pop)
      fifo_count_nxt = fifo_count + 1'b1;
    else if (pop && !push)
      fifo_count_nxt = fifo_count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clock_sreset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = HUNT;
      HUNT:  if (push) state_nxt = (last_beat || short_beat) ? DRAIN : RUN;
      RUN:   if (last_beat || short_beat) state_nxt = DRAIN;
      DRAIN: if (fifo_count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    st_ready = 1'b0;
    rm_write = 1'b0;
    case (state)
      HUNT:  st_ready = 1'b1;
      RUN: begin
        st_ready = !fifo_full && (accepted < target);
        rm_write = !fifo_empty;
      end
      DRAIN: rm_write = !fifo_empty;
      default: ;
    endcase
  end

  // Storage array carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= st_data;
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      pointer       <= '0;
      word_count    <= '0;
      target        <= '0;
      accepted      <= '0;
      words_written <= '0;
      short_pkt     <= 1'b0;
      no_eop        <= 1'b0;
      rm_address    <= '0;
    end else begin
      if (s_write) begin
        case (s_address)
          4'h1: pointer    <= s_writedata;
          4'h2: word_count <= s_writedata[23:0];
          default: ;
        endcase
      end
      if (go) begin
        rm_address    <= pointer;
        target        <= word_count;
        accepted      <= '0;
        words_written <= '0;
        short_pkt     <= 1'b0;
        no_eop        <= 1'b0;
      end
      if (push) begin
        accepted <= accepted_inc;
        if (short_beat)
          short_pkt <= 1'b1;
        if (last_beat && !st_eop)
          no_eop <= 1'b1;
      end
      if (pop) begin
        rm_address    <= rm_address + 32'd2;
        words_written <= words_written + 24'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      4'h0: rd_mux = {28'b0, no_eop, short_pkt, busy, 1'b0};
      4'h1: rd_mux = pointer;
      4'h2: rd_mux = {8'b0, word_count};
      4'h3: rd_mux = {8'b0, words_written};
      default: ;
    endcase
  end

  // One wait state per read: data captured on the first cycle, returned on the second.
  assign s_waitrequest = s_read && !read_latency;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      read_latency <= 1'b0;
      s_readdata   <= '0;
    end else if (s_read && !read_latency) begin
      read_latency <= 1'b1;
      s_readdata   <= rd_mux;
    end else begin
      read_latency <= 1'b0;
    end
  end

endmodule
